// File: rtl/ifu_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_prefetch_pkg
//   Shared definitions for the instruction prefetch unit: the NOP encoding
//   presented while no instruction is available, the default reset PC, the
//   fetch-unit state encoding and the layout of one buffered fetch entry.
// ----------------------------------------------------------------------------
package ifu_prefetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } ifu_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  // Word-aligned version of a byte address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ----------------------------------------------------------------------------
// ifu_fifo
//   Synchronous first-in/first-out buffer with parameterized width and depth
//   (depth must be a power of two). rdata always shows the head entry.
//   Flush empties the buffer and takes priority over push and pop.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (control state only)
//   flush  in   discard all entries
//   push   in   write wdata at the tail (ignored when full)
//   pop    in   drop the head entry (ignored when empty)
//   wdata  in   WIDTH  entry to write
//   rdata  out  WIDTH  head entry (undefined contents when empty)
//   empty  out  no entries stored
//   full   out  DEPTH entries stored
//   count  out  number of stored entries
// ----------------------------------------------------------------------------
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// ----------------------------------------------------------------------------
// ifu_prefetch
//   Instruction fetch unit feeding the if_id register. Owns the PC, issues
//   word fetches on a req/gnt/rsp bus with several requests in flight,
//   buffers in-order responses in a small FIFO and presents one instruction
//   plus its address per cycle. A jump from execute flushes the buffer and
//   discards every response still in flight.
//
//   Optional feature (define IFU_BYPASS_EN): when the buffer is empty a live
//   response is forwarded combinationally to inst_o in its arrival cycle;
//   if it is consumed (hold_i = 0) it is not written into the buffer.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   jump_en_i     in   redirect request from execute
//   jump_addr_i   in   32  redirect target (aligned down to a word)
//   hold_i        in   downstream stall; instruction not consumed
//   req_o         out  fetch request valid
//   req_addr_o    out  32  fetch address (word aligned)
//   req_ready_i   in   bus grant; accepted when req_o && req_ready_i
//   rsp_valid_i   in   response valid (in request order)
//   rsp_data_i    in   32  fetched instruction word
//   inst_o        out  32  instruction to if_id (NOP when none)
//   inst_addr_o   out  32  address of inst_o (0 when none)
//   inst_valid_o  out  inst_o holds a real instruction
// ----------------------------------------------------------------------------
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        req_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  ifu_state_t    state;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [OCW-1:0] total_out;
  logic [OCW-1:0] drop_cnt;

  logic [FCW-1:0] fifo_cnt;
  logic           fifo_empty;
  logic           fifo_full;
  logic           fifo_push;
  logic           fifo_pop;
  fetch_entry_t   fifo_wdata;
  fetch_entry_t   fifo_rdata;

  logic           accept;
  logic           rsp_live;
  logic           bypass_show;
  logic           bypass_take;
  logic [31:0]    credits_used;

  // Buffer slots already claimed: stored entries plus live requests in
  // flight. Keeping this below FIFO_DEPTH means a push never meets a full
  // buffer, so no backpressure toward the bus is needed.
  assign credits_used = 32'(fifo_cnt) + 32'(total_out) - 32'(drop_cnt);

  assign req_o = (state == ST_RUN) && !jump_en_i
              && (credits_used < 32'(FIFO_DEPTH))
              && (32'(total_out) < 32'(MAX_OUTSTANDING));
  assign req_addr_o = pc;
  assign accept     = req_o && req_ready_i;

  // A response is live when it is neither owed to a pre-jump request nor
  // arriving in the cycle of a jump.
  assign rsp_live = rsp_valid_i && (drop_cnt == '0) && !jump_en_i;

`ifdef IFU_BYPASS_EN
  assign bypass_show = rsp_live && fifo_empty;
  assign bypass_take = bypass_show && !hold_i;
`else
  assign bypass_show = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign fifo_push  = rsp_live && !bypass_take;
  assign fifo_pop   = !fifo_empty && !hold_i && !jump_en_i;
  assign fifo_wdata = '{addr: rsp_pc, data: rsp_data_i};

  ifu_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (jump_en_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = NOP_INST;
    inst_addr_o  = 32'h0;
    if (!fifo_empty) begin
      inst_valid_o = 1'b1;
      inst_o       = fifo_rdata.data;
      inst_addr_o  = fifo_rdata.addr;
    end else if (bypass_show) begin
      inst_valid_o = 1'b1;
      inst_o       = rsp_data_i;
      inst_addr_o  = rsp_pc;
    end
  end

  // Control state: FSM, PCs and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      rsp_pc    <= RESET_PC;
      total_out <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= ST_RUN;
      total_out <= total_out + OCW'(accept) - OCW'(rsp_valid_i);
      if (jump_en_i) begin
        // In BOOT nothing is in flight, so only the PCs change here.
        pc       <= word_align(jump_addr_i);
        rsp_pc   <= word_align(jump_addr_i);
        drop_cnt <= total_out - OCW'(rsp_valid_i);
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (rsp_valid_i) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - OCW'(1);
          else                rsp_pc   <= rsp_pc + 32'd4;
        end
      end
    end
  end

  // fifo_full is implied by the credit rule and needs no consumer here.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        req_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .req_o        (req_o),
    .req_addr_o   (req_addr_o),
    .req_ready_i  (req_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Bus side: requests the DUT actually got granted, with response due cycle.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t bus_q[$];

  // Reference model: fetch pointer, requests in flight (live or abandoned by
  // a jump) and the buffered instructions awaiting consumption.
  typedef struct { logic [31:0] addr; bit live; } inf_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  inf_t        m_inf[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  bit          m_run;

  task automatic model_reset();
    m_inf.delete();
    m_buf.delete();
    m_pc  = RESET_PC;
    m_run = 1'b0;
  endtask

  function automatic int live_count();
    int n = 0;
    foreach (m_inf[i]) if (m_inf[i].live) n++;
    return n;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'h0000_0101;
      1:       return 32'h0000_0020;
      2:       return 32'hFFFF_FFF5;
      default: return $urandom;
    endcase
  endfunction

  task automatic reset_checks();
    chk("rst_req_o", req_o, 1'b0);
    chk("rst_inst_valid", inst_valid_o, 1'b0);
    chk("rst_inst_nop", inst_o, 32'h0000_0013);
    chk("rst_inst_addr", inst_addr_o, 32'h0);
    chk("rst_req_addr", req_addr_o, RESET_PC);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic run_cycle(input int hold_pct, input int ready_pct, input int jump_pct,
                           input int lat_lo, input int lat_hi);
    bit          exp_req;
    bit          byp;
    bit          exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_iaddr;
    inf_t        r;

    hold_i      = ($urandom_range(99) < hold_pct);
    req_ready_i = ($urandom_range(99) < ready_pct);
    jump_en_i   = ($urandom_range(99) < jump_pct);
    jump_addr_i = pick_target();
    if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = mem_word(bus_q[0].addr);
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = $urandom;
    end
    #1;

    exp_req = m_run && !jump_en_i
           && ((m_buf.size() + live_count()) < DEPTH)
           && (m_inf.size() < MAX_OUT);
    byp = 1'b0;
`ifdef IFU_BYPASS_EN
    byp = (m_buf.size() == 0) && rsp_valid_i && (m_inf.size() > 0)
       && m_inf[0].live && !jump_en_i;
`endif
    if (m_buf.size() > 0) begin
      exp_valid = 1'b1; exp_inst = m_buf[0].data; exp_iaddr = m_buf[0].addr;
    end else if (byp) begin
      exp_valid = 1'b1; exp_inst = mem_word(m_inf[0].addr); exp_iaddr = m_inf[0].addr;
    end else begin
      exp_valid = 1'b0; exp_inst = 32'h0000_0013; exp_iaddr = 32'h0;
    end

    chk("req_o", req_o, exp_req);
    chk("req_addr", req_addr_o, m_pc);
    chk("inst_valid", inst_valid_o, exp_valid);
    chk("inst", inst_o, exp_inst);
    chk("inst_addr", inst_addr_o, exp_iaddr);

    if (jump_en_i) begin
      if (rsp_valid_i && m_inf.size() > 0) void'(m_inf.pop_front());
      foreach (m_inf[i]) m_inf[i].live = 1'b0;
      m_buf.delete();
      m_pc = {jump_addr_i[31:2], 2'b00};
    end else begin
      if (m_buf.size() > 0 && !hold_i) void'(m_buf.pop_front());
      if (rsp_valid_i && m_inf.size() > 0) begin
        r = m_inf.pop_front();
        if (r.live && !(byp && !hold_i))
          m_buf.push_back('{addr: r.addr, data: mem_word(r.addr)});
      end
      if (exp_req && req_ready_i) begin
        m_inf.push_back('{addr: m_pc, live: 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1'b1;

    if (rsp_valid_i) void'(bus_q.pop_front());
    if (req_o && req_ready_i)
      bus_q.push_back('{addr: req_addr_o, due: cyc + $urandom_range(lat_hi, lat_lo)});
    chk("outstanding_le_max", (bus_q.size() <= MAX_OUT), 1'b1);

    cyc++;
    @(negedge clk);
  endtask

  // Phase table: cycles, hold %, ready %, jump %, min latency, max latency.
  int cfg [8][6] = '{
    '{ 40,   0, 100,  0, 1, 1},
    '{ 20, 100, 100,  0, 1, 1},
    '{ 30,   0, 100,  0, 1, 1},
    '{120,  30, 100,  8, 1, 2},
    '{120,  20,  50,  5, 3, 3},
    '{150,  40,  70, 15, 1, 4},
    '{300,  30,  60, 10, 1, 5},
    '{200,  50,  80, 25, 1, 2}
  };

  initial begin
    rst_n       = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = 32'h0;
    hold_i      = 1'b0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0;
    model_reset();

    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    for (int p = 0; p < 8; p++) begin
      if (p == 6) begin
        // Reset in the middle of traffic; the bus forgets pending responses.
        rst_n       = 1'b0;
        jump_en_i   = 1'b0;
        hold_i      = 1'b0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        bus_q.delete();
        model_reset();
        rst_n = 1'b1;
      end
      for (int c = 0; c < cfg[p][0]; c++)
        run_cycle(cfg[p][1], cfg[p][2], cfg[p][3], cfg[p][4], cfg[p][5]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
